// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and write-back requester indices.
package cpu_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   localparam int WB_ALU    = 0;
   localparam int WB_LOAD   = 1;
   localparam int WB_MULDIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter
   import cpu_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant
);

   logic [PW:0] idx;
   logic        found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         // One spare bit so ptr+k cannot overflow before the modulo fold.
         idx = {1'b0, ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!found && req[idx[PW-1:0]]) begin
            grant[idx[PW-1:0]] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-back controller: round-robin shares the single write
// port among NREQ producers and tracks pending writes for RAW stall checks.
module wb_port_arbiter
   import cpu_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int DW   = REG_DW,
   parameter int AW   = REG_AW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               claim_valid,
   input  logic [AW-1:0]      claim_addr,
   input  logic [AW-1:0]      q_addr1,
   input  logic [AW-1:0]      q_addr2,
   output logic               q_busy1,
   output logic               q_busy2,
   output logic               we,
   output logic [AW-1:0]      waddr,
   output logic [DW-1:0]      win
);

   localparam int PW = $clog2(NREQ);
   localparam int NR = 2**AW;

   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] grant;
   logic            hs;
   logic [PW-1:0]   gidx;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic [NR-1:0]   busy;
   logic [NR-1:0]   busy_nxt;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   assign req_ready = grant;
   assign hs        = |grant;

   always_comb begin
      gidx     = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gidx     = PW'(i);
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Clear is applied before set so a same-edge claim keeps the register pending.
   always_comb begin
      busy_nxt = busy;
      if (we) busy_nxt[waddr] = 1'b0;
      if (claim_valid && claim_addr != AW'(REG_ZERO)) busy_nxt[claim_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we     <= 1'b0;
         waddr  <= '0;
         win    <= '0;
         rr_ptr <= '0;
         busy   <= '0;
      end else begin
         busy <= busy_nxt;
         if (hs) begin
            we     <= (sel_addr != AW'(REG_ZERO));
            waddr  <= sel_addr;
            win    <= sel_data;
            rr_ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
         end else begin
            we <= 1'b0;
         end
      end
   end

   assign q_busy1 = busy[q_addr1];
   assign q_busy2 = busy[q_addr2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;
   import cpu_pkg::*;

   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int AW   = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               claim_valid;
   logic [AW-1:0]      claim_addr;
   logic [AW-1:0]      q_addr1;
   logic [AW-1:0]      q_addr2;
   logic               q_busy1;
   logic               q_busy2;
   logic               we;
   logic [AW-1:0]      waddr;
   logic [DW-1:0]      win;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .claim_valid (claim_valid),
      .claim_addr  (claim_addr),
      .q_addr1     (q_addr1),
      .q_addr2     (q_addr2),
      .q_busy1     (q_busy1),
      .q_busy2     (q_busy2),
      .we          (we),
      .waddr       (waddr),
      .win         (win)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all_idle(input string tag);
      for (int a = 0; a < 32; a++) begin
         q_addr1 = AW'(a);
         q_addr2 = AW'(31 - a);
         #1;
         check({tag, "_q1"}, 64'(q_busy1), 64'd0);
         check({tag, "_q2"}, 64'(q_busy2), 64'd0);
      end
   endtask

   // Fairness table: expected one-hot grant per cycle starting from rr_ptr=0.
   logic [NREQ-1:0] fair_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [AW-1:0]   fair_addr [3] = '{5'd1, 5'd2, 5'd3};
   logic [DW-1:0]   fair_data [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};

   initial begin
      reset       = 1'b0;
      req_valid   = '0;
      req_addr    = '0;
      req_data    = '0;
      claim_valid = 1'b0;
      claim_addr  = '0;
      q_addr1     = '0;
      q_addr2     = '0;

      // Reset state
      @(negedge clk);
      check("rst_we", 64'(we), 64'd0);
      check("rst_waddr", 64'(waddr), 64'd0);
      check("rst_win", 64'(win), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_we", 64'(we), 64'd0);
      check("idle_ready", 64'(req_ready), 64'd0);
      check_all_idle("idle");

      // Single write to r5 from the load unit
      @(negedge clk);
      claim_valid = 1'b1;
      claim_addr  = 5'd5;
      q_addr1     = 5'd5;
      @(negedge clk);
      claim_valid = 1'b0;
      check("sw_busy_claimed", 64'(q_busy1), 64'd1);
      @(negedge clk);
      req_valid = 3'b010;
      req_addr[WB_LOAD*AW +: AW] = 5'd5;
      req_data[WB_LOAD*DW +: DW] = 32'hDEAD_BEEF;
      #1;
      check("sw_ready", 64'(req_ready), 64'b010);
      @(negedge clk);
      req_valid = '0;
      check("sw_we", 64'(we), 64'd1);
      check("sw_waddr", 64'(waddr), 64'd5);
      check("sw_win", 64'(win), 64'hDEAD_BEEF);
      check("sw_busy_wcycle", 64'(q_busy1), 64'd1);
      @(negedge clk);
      check("sw_we_off", 64'(we), 64'd0);
      check("sw_busy_clear", 64'(q_busy1), 64'd0);

      // Bring rr_ptr back to 0 via a lone grant to requester 2
      req_valid = 3'b100;
      req_addr[WB_MULDIV*AW +: AW] = 5'd3;
      req_data[WB_MULDIV*DW +: DW] = 32'h0000_0033;
      #1;
      check("ptr_ready", 64'(req_ready), 64'b100);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);

      // Fairness: all three valid for six cycles
      for (int i = 0; i < 3; i++) begin
         req_addr[i*AW +: AW] = fair_addr[i];
         req_data[i*DW +: DW] = fair_data[i];
      end
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("fair_grant%0d", c), 64'(req_ready), 64'(fair_exp[c]));
         if (c > 0) begin
            check($sformatf("fair_we%0d", c), 64'(we), 64'd1);
            check($sformatf("fair_waddr%0d", c), 64'(waddr), 64'(fair_addr[(c-1)%3]));
            check($sformatf("fair_win%0d", c), 64'(win), 64'(fair_data[(c-1)%3]));
         end
         @(negedge clk);
      end
      req_valid = '0;
      check("fair_we6", 64'(we), 64'd1);
      check("fair_waddr6", 64'(waddr), 64'd3);
      check("fair_win6", 64'(win), 64'hC0C0_0003);
      @(negedge clk);
      check("fair_we_off", 64'(we), 64'd0);

      // r0: claim and write of register zero
      claim_valid = 1'b1;
      claim_addr  = 5'd0;
      q_addr1     = 5'd0;
      req_valid   = 3'b001;
      req_addr[WB_ALU*AW +: AW] = 5'd0;
      req_data[WB_ALU*DW +: DW] = 32'h0000_1234;
      #1;
      check("r0_ready", 64'(req_ready), 64'b001);
      check("r0_busy_hs", 64'(q_busy1), 64'd0);
      @(negedge clk);
      claim_valid = 1'b0;
      req_valid   = '0;
      check("r0_we", 64'(we), 64'd0);
      check("r0_busy_after", 64'(q_busy1), 64'd0);
      @(negedge clk);
      check("r0_we_late", 64'(we), 64'd0);

      // Set/clear collision on r7 (rr_ptr now 1)
      claim_valid = 1'b1;
      claim_addr  = 5'd7;
      q_addr2     = 5'd7;
      @(negedge clk);
      claim_valid = 1'b0;
      req_valid   = 3'b010;
      req_addr[WB_LOAD*AW +: AW] = 5'd7;
      req_data[WB_LOAD*DW +: DW] = 32'h0000_0077;
      #1;
      check("col_ready", 64'(req_ready), 64'b010);
      @(negedge clk);
      req_valid   = '0;
      claim_valid = 1'b1;
      claim_addr  = 5'd7;
      check("col_we", 64'(we), 64'd1);
      check("col_waddr", 64'(waddr), 64'd7);
      @(negedge clk);
      claim_valid = 1'b0;
      check("col_busy", 64'(q_busy2), 64'd1);
      @(negedge clk);
      check("col_busy_hold", 64'(q_busy2), 64'd1);

      // Asynchronous reset between handshake and write cycle (rr_ptr now 2)
      claim_valid = 1'b1;
      claim_addr  = 5'd9;
      q_addr1     = 5'd9;
      @(negedge clk);
      claim_valid = 1'b0;
      req_valid   = 3'b100;
      req_addr[WB_MULDIV*AW +: AW] = 5'd9;
      req_data[WB_MULDIV*DW +: DW] = 32'h0000_ABCD;
      #1;
      check("ar_ready", 64'(req_ready), 64'b100);
      check("ar_busy_pre", 64'(q_busy1), 64'd1);
      @(posedge clk);
      #2;
      req_valid = '0;
      check("ar_we_pre", 64'(we), 64'd1);
      reset = 1'b0;
      #1;
      check("ar_we_drop", 64'(we), 64'd0);
      check("ar_waddr_drop", 64'(waddr), 64'd0);
      check("ar_win_drop", 64'(win), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("ar_we_after", 64'(we), 64'd0);
      check_all_idle("ar_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back controller for the 32x32 CPU register file: shares its single write port (`we`/`waddr`/`win`) among `NREQ` result producers (ALU pipe, load unit, mult/div) via valid/ready handshakes and round-robin arbitration. It also keeps a per-register pending-write scoreboard so that issue logic can stall on RAW hazards. It sits between the execution units and the register file; its write outputs drive the register-file write port directly.

## Interface
- `NREQ`, 3, number of write-back requesters (2..8)
- `DW`, 32, data width
- `AW`, 5, register address width (2**AW registers)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `req_valid`  in  NREQ  requester i has a result
- `req_addr`  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- `req_data`  in  NREQ*DW  result of requester i, slice [i*DW +: DW]
- `req_ready`  out  NREQ  one-hot grant; handshake when `req_valid[i] & req_ready[i]`
- `claim_valid`  in  1  issue marks a destination pending
- `claim_addr`  in  AW  register being claimed
- `q_addr1`, `q_addr2`  in  AW  scoreboard query addresses
- `q_busy1`, `q_busy2`  out  1  combinational: queried register has a pending write
- `we`  out  1  register-file write enable (registered)
- `waddr`  out  AW  register-file write address (registered)
- `win`  out  DW  register-file write data (registered)

## Operation
- Arbitration: round-robin over requesters with `req_valid` set, starting at pointer `rr_ptr`. `req_ready` is combinational, at most one bit set, and 0 when no valid requester exists. It does not depend on output stall: the write port accepts one result every cycle.
- On handshake by requester g: the output registers load `we<=1`, `waddr<=req_addr[g]`, `win<=req_data[g]`, and `rr_ptr<=g+1` (wraps NREQ-1 -> 0). With no handshake: `we<=0`, `waddr`/`win` hold, and `rr_ptr` holds.
- r0: a handshake with `req_addr==0` is accepted (ready/consumed), but the output loads `we<=0`. `we` is never 1 with `waddr==0`.
- Scoreboard: `busy[2**AW]` bits.
  - Set at the edge where `claim_valid=1 && claim_addr!=0`.
  - Cleared at the edge where output `we=1`, for `waddr`. This is the edge at which the register file commits the value.
  - Same register set and cleared at the same edge: set wins, so `busy` stays 1. This supports back-to-back producers with the same destination.
  - `busy[0]` is always 0.
- `q_busyN = busy[q_addrN]`. There is no bypass: a reader sees 0 only once the register file already holds the value.
- Claiming an already-busy register is legal. A single bit tracks it, and the first write clears it; issue logic must not issue a second writer to a busy destination.

## Timing
- Reset values: `we=0`, `waddr=0`, `win=0`, `rr_ptr=0`, all `busy=0`; `req_ready=0` while `req_valid=0`.
- Latency: handshake at edge t -> `we/waddr/win` valid during cycle t+1 -> register-file write at edge t+1 -> `busy` cleared at edge t+1 -> `q_busy=0` in cycle t+2.
- Throughput: 1 write per cycle. A requester holding valid waits at most NREQ-1 cycles.
- Requesters must hold `req_addr`/`req_data` stable while valid and not ready.
- Reset asserted mid-operation: a pending output write is dropped (`we` forced 0 asynchronously) and the scoreboard is cleared.

## Structure
- Shared package `cpu_pkg` holds `REG_AW=5`, `REG_DW=32`, the `REG_ZERO` constant and the requester index constants (`WB_ALU=0`, `WB_LOAD=1`, `WB_MULDIV=2`).
- One natural sub-module: `rr_arbiter` (parameterized NREQ; request vector and pointer in, one-hot grant out; combinational). Pointer update stays in the parent.
- The scoreboard and output registers live in the parent.

## Test plan
- Reset release, no traffic -> `we=0`, `req_ready=0`, `q_busy1/2=0` for all addresses.
- Single write: claim r5, then 2 cycles later `req_valid[1]=1`, addr 5, data 0xDEADBEEF -> `req_ready=3'b010` that cycle, next cycle `we=1 waddr=5 win=0xDEADBEEF`, `q_busy(5)` 1 until the following cycle, then 0.
- Fairness: all three valid for 6 cycles, `rr_ptr=0` -> grants 0,1,2,0,1,2 and `we=1` on 6 consecutive cycles.
- r0: claim r0 and write r0 data 0x1234 -> handshake occurs, `we` stays 0, `q_busy(0)=0` throughout.
- Set/clear collision: r7 busy with its write on the output (`we=1 waddr=7`) while `claim_addr=7` in the same cycle -> `q_busy(7)=1` afterwards.
- Asynchronous reset asserted between handshake and write cycle -> `we` drops to 0 immediately with no clock edge; all busy bits are 0 after release.
